// File: rtl/acc_risc_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers for the accumulator RISC core.
package acc_risc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // True for opcodes whose execute phase needs a memory transfer.
    function automatic logic op_uses_mem(input logic [2:0] op);
        return (op != OP_HLT) && (op != OP_SKZ) && (op != OP_JMP);
    endfunction

endpackage

// File: rtl/acc_risc_alu.sv
// Combinational accumulator ALU: computes the new accumulator for LDA/ADD/AND/XOR.
module acc_risc_alu
    import acc_risc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = acc;
        case (op)
            OP_ADD:  result = acc + operand;
            OP_AND:  result = acc & operand;
            OP_XOR:  result = acc ^ operand;
            OP_LDA:  result = operand;
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/acc_risc_core.sv
// Accumulator RISC core with req/ack memory port and debug taps.
// Optional performance counters are enabled by defining ACC_RISC_PERF_CNT_EN.
module acc_risc_core
    import acc_risc_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halt,
    output logic [ADDR_W-1:0] dbg_pc,
    output logic [DATA_W-1:0] dbg_ir,
    output logic [DATA_W-1:0] dbg_acc
`ifdef ACC_RISC_PERF_CNT_EN
    ,
    output logic [31:0]       instr_cnt,
    output logic [31:0]       cycle_cnt
`endif
);

    localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              halt_q, halt_d;
    logic [DATA_W-1:0] alu_result;
    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic              xfer_done;

    if (DATA_W < ADDR_W + 3) begin : g_bad_width
        $error("acc_risc_core: DATA_W must be at least ADDR_W+3");
    end

    if (DATA_W > ADDR_W + 3) begin : g_ir_unused
        logic unused_ir_hi;
        assign unused_ir_hi = ^ir_q[DATA_W-1:ADDR_W+3];
    end

    assign opcode    = ir_q[ADDR_W+2:ADDR_W];
    assign operand   = ir_q[ADDR_W-1:0];
    assign xfer_done = mem_req & mem_ack;

    acc_risc_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .op     (opcode),
        .acc    (acc_q),
        .operand(mem_rdata),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_INIT;
            ir_q    <= '0;
            acc_q   <= '0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        halt_d  = halt_q;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (xfer_done) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + PC_ONE;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_HLT: begin
                        halt_d  = 1'b1;
                        state_d = S_HALT;
                    end
                    OP_SKZ: begin
                        if (acc_q == '0) begin
                            pc_d = pc_q + PC_ONE;
                        end
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_d    = operand;
                        state_d = S_FETCH;
                    end
                    default: begin
                        if (xfer_done) begin
                            if (opcode != OP_STO) begin
                                acc_d = alu_result;
                            end
                            state_d = S_FETCH;
                        end
                    end
                endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Port outputs decode from registered state only, so they stay put across wait states
    // and drop as soon as the asynchronous reset hits.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end
            S_EXEC: begin
                if (op_uses_mem(opcode)) begin
                    mem_req  = 1'b1;
                    mem_addr = operand;
                    if (opcode == OP_STO) begin
                        mem_we    = 1'b1;
                        mem_wdata = acc_q;
                    end
                end
            end
            default: mem_req = 1'b0;
        endcase
    end

    assign halt    = halt_q;
    assign dbg_pc  = pc_q;
    assign dbg_ir  = ir_q;
    assign dbg_acc = acc_q;

`ifdef ACC_RISC_PERF_CNT_EN
    logic [31:0] instr_cnt_q, cycle_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            if (state_q != S_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
            if ((state_q == S_EXEC) && (state_d != S_EXEC)) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_acc_risc_core.sv
// Directed bench for acc_risc_core: memory model with programmable wait states and a write scoreboard.
module tb_acc_risc_core;

    localparam int DW = 8;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          mem_req, mem_we, mem_ack, halt;
    logic [AW-1:0] mem_addr, dbg_pc;
    logic [DW-1:0] mem_wdata, mem_rdata, dbg_ir, dbg_acc;

    logic          b_req, b_we, b_halt;
    logic [AW-1:0] b_addr, b_pc;
    logic [DW-1:0] b_wdata, b_rdata, b_ir, b_acc;

`ifdef ACC_RISC_PERF_CNT_EN
    logic [31:0]   instr_cnt, cycle_cnt;
`endif

    logic [DW-1:0] mem  [32];
    logic [DW-1:0] bmem [32];
    int            nwait = 0;
    int            wcnt = 0;
    wr_t           exp_wr[$];
    int            checks = 0;
    int            errors = 0;

    logic          pend = 1'b0;
    logic [AW-1:0] s_addr;
    logic          s_we;
    logic [DW-1:0] s_wdata;

    always #5 clk = ~clk;

    acc_risc_core #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .RESET_PC(0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .halt     (halt),
        .dbg_pc   (dbg_pc),
        .dbg_ir   (dbg_ir),
        .dbg_acc  (dbg_acc)
`ifdef ACC_RISC_PERF_CNT_EN
        ,
        .instr_cnt(instr_cnt),
        .cycle_cnt(cycle_cnt)
`endif
    );

    // Second core exercises the pc wrap from a top-of-memory reset vector.
    acc_risc_core #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .RESET_PC(31)
    ) dut_wrap (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_req  (b_req),
        .mem_we   (b_we),
        .mem_addr (b_addr),
        .mem_wdata(b_wdata),
        .mem_ack  (b_req),
        .mem_rdata(b_rdata),
        .halt     (b_halt),
        .dbg_pc   (b_pc),
        .dbg_ir   (b_ir),
        .dbg_acc  (b_acc)
`ifdef ACC_RISC_PERF_CNT_EN
        ,
        .instr_cnt(),
        .cycle_cnt()
`endif
    );

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    assign mem_ack   = mem_req && (wcnt == nwait);
    assign mem_rdata = mem[mem_addr];
    assign b_rdata   = bmem[b_addr];

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            wcnt <= 0;
            if (mem_we) begin
                chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
                if (exp_wr.size() != 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(e.data));
                end
                mem[mem_addr] <= mem_wdata;
            end
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    // Request attributes must not move while a transfer is waiting for ack.
    always @(negedge clk) begin
        if (rst_n && pend) begin
            chk("hold_req", 32'(mem_req), 32'd1);
            chk("hold_addr", 32'(mem_addr), 32'(s_addr));
            chk("hold_we", 32'(mem_we), 32'(s_we));
            chk("hold_wdata", 32'(mem_wdata), 32'(s_wdata));
        end
        pend    = rst_n && mem_req && !mem_ack;
        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wdata = mem_wdata;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic enter_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_wr.delete();
        for (int i = 0; i < 32; i++) begin
            mem[i]  = '0;
            bmem[i] = '0;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_to_halt(input int start, output int cyc);
        cyc = start;
        while (!halt && cyc < 300) begin
            step(1);
            cyc++;
        end
        chk("halt_reached", 32'(halt), 32'd1);
    endtask

    int cyc;
    int found;

    initial begin
        // Test 1: zero-wait program; A5 is LDA 5, so address 5 is seeded with 05 as well.
        enter_reset();
        nwait = 0;
        mem[0] = 8'hA5; mem[1] = 8'h55; mem[2] = 8'hD6; mem[3] = 8'h00;
        mem[5] = 8'h05; mem[20] = 8'h05; mem[21] = 8'h03;
        bmem[31] = 8'h20; bmem[0] = 8'hEA; bmem[1] = 8'h00;
        exp_wr.push_back('{addr: 5'd22, data: 8'h08});
        #2;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_pc", 32'(dbg_pc), 32'd0);
        chk("rst_ir", 32'(dbg_ir), 32'd0);
        chk("rst_acc", 32'(dbg_acc), 32'd0);
        chk("rst_halt", 32'(halt), 32'd0);
        chk("rst_wrap_pc", 32'(b_pc), 32'd31);
        release_reset();
        step(1);
        chk("t1_first_req", 32'(mem_req), 32'd1);
        chk("t1_first_addr", 32'(mem_addr), 32'd0);
        // Test 4 runs alongside on the wrap core: fetch 31, pc -> 0, SKZ skip -> 1.
        chk("t4_fetch31", 32'(b_addr), 32'd31);
        step(1);
        chk("t4_pc_wrap", 32'(b_pc), 32'd0);
        step(1);
        chk("t4_pc_skip", 32'(b_pc), 32'd1);
        chk("t4_next_req", 32'(b_req), 32'd1);
        chk("t4_next_addr", 32'(b_addr), 32'd1);
        chk("t4_next_we", 32'(b_we), 32'd0);
        run_to_halt(3, cyc);
        chk("t1_halt_cycle", 32'(cyc), 32'd9);
        chk("t1_mem22", 32'(mem[22]), 32'h08);
        chk("t1_acc", 32'(dbg_acc), 32'h08);
        chk("t1_pc", 32'(dbg_pc), 32'd4);
        chk("t1_sb_empty", 32'(exp_wr.size()), 32'd0);
        chk("t4_halt", 32'(b_halt), 32'd1);
`ifdef ACC_RISC_PERF_CNT_EN
        chk("t6_instr", instr_cnt, 32'd4);
        chk("t6_cycle", cycle_cnt, 32'd9);
        step(5);
        chk("t6_instr_frozen", instr_cnt, 32'd4);
        chk("t6_cycle_frozen", cycle_cnt, 32'd9);
`endif
        step(3);
        chk("t1_req_after_halt", 32'(mem_req), 32'd0);

        // Test 2: same program, 3 wait cycles on each of its 7 transfers.
        enter_reset();
        nwait = 3;
        mem[0] = 8'hA5; mem[1] = 8'h55; mem[2] = 8'hD6; mem[3] = 8'h00;
        mem[5] = 8'h05; mem[20] = 8'h05; mem[21] = 8'h03;
        exp_wr.push_back('{addr: 5'd22, data: 8'h08});
        release_reset();
        run_to_halt(0, cyc);
        chk("t2_halt_cycle", 32'(cyc), 32'(9 + 7 * 3));
        chk("t2_mem22", 32'(mem[22]), 32'h08);
        chk("t2_sb_empty", 32'(exp_wr.size()), 32'd0);

        // Test 3a: acc == 0 so SKZ skips the JMP at address 2.
        enter_reset();
        nwait = 0;
        mem[0] = 8'hB8; mem[1] = 8'h20; mem[2] = 8'hEA; mem[3] = 8'h00;
        mem[24] = 8'h00;
        release_reset();
        step(5);
        chk("t3a_pc_skip", 32'(dbg_pc), 32'd3);
        run_to_halt(5, cyc);
        chk("t3a_halt_pc", 32'(dbg_pc), 32'd4);
        chk("t3a_ir", 32'(dbg_ir), 32'h00);

        // Test 3b: acc != 0 so the JMP is taken.
        enter_reset();
        mem[0] = 8'hB8; mem[1] = 8'h20; mem[2] = 8'hEA; mem[3] = 8'h00;
        mem[24] = 8'h07;
        release_reset();
        step(5);
        chk("t3b_pc_noskip", 32'(dbg_pc), 32'd2);
        step(2);
        chk("t3b_pc_jmp", 32'(dbg_pc), 32'd10);
        chk("t3b_acc", 32'(dbg_acc), 32'h07);
        run_to_halt(7, cyc);
        chk("t3b_halt_pc", 32'(dbg_pc), 32'd11);

        // Test 5: reset lands while the STO is waiting for ack.
        enter_reset();
        nwait = 3;
        mem[0] = 8'hB4; mem[1] = 8'hD6; mem[2] = 8'h00;
        mem[20] = 8'h33; mem[22] = 8'h5A;
        release_reset();
        found = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (mem_req && mem_we) begin
                found = 1;
                break;
            end
        end
        chk("t5_sto_seen", 32'(found), 32'd1);
        chk("t5_sto_wdata", 32'(mem_wdata), 32'h33);
        rst_n = 1'b0;
        #1;
        chk("t5_req_drop", 32'(mem_req), 32'd0);
        chk("t5_we_drop", 32'(mem_we), 32'd0);
        step(1);
        chk("t5_target_kept", 32'(mem[22]), 32'h5A);
        exp_wr.push_back('{addr: 5'd22, data: 8'h33});
        rst_n = 1'b1;
        step(1);
        chk("t5_restart_req", 32'(mem_req), 32'd1);
        chk("t5_restart_addr", 32'(mem_addr), 32'd0);
        chk("t5_restart_we", 32'(mem_we), 32'd0);
        run_to_halt(1, cyc);
        chk("t5_mem22", 32'(mem[22]), 32'h33);
        chk("t5_sb_empty", 32'(exp_wr.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
